// File: rtl/gth_link_bringup_ctrl.sv
// Bring-up and recovery sequencer for one GTH transceiver wizard instance.
// Define GTH_CTRL_STABLE_FILTER_EN to require STABLE_CYC consecutive good RX cycles before LINK_UP.
module gth_link_bringup_ctrl #(
    parameter int unsigned RST_HOLD_CYC = 16,
    parameter int unsigned TIMEOUT_CYC  = 1000000,
    parameter int unsigned MAX_RETRY    = 7,
    parameter int unsigned STABLE_CYC   = 64
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       restart_in,
    input  logic       gtpowergood_in,
    input  logic       reset_tx_done_in,
    input  logic       reset_rx_done_in,
    input  logic       rx_cdr_stable_in,
    output logic       reset_all_out,
    output logic       reset_rx_datapath_out,
    output logic       datagen_en_out,
    output logic       link_up_out,
    output logic       fail_out,
    output logic [3:0] retry_cnt_out,
    output logic [2:0] state_out
);

    localparam logic [2:0] PWR_WAIT   = 3'd0;
    localparam logic [2:0] RST_HOLD   = 3'd1;
    localparam logic [2:0] WAIT_TX    = 3'd2;
    localparam logic [2:0] WAIT_RX    = 3'd3;
    localparam logic [2:0] LINK_UP    = 3'd4;
    localparam logic [2:0] RX_RECOVER = 3'd5;
    localparam logic [2:0] TIMEOUT    = 3'd6;
    localparam logic [2:0] FAIL       = 3'd7;

    localparam int unsigned HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]        RETRY_LIM = 4'(MAX_RETRY);

    logic [3:0]        meta_q, sync_q;
    logic              s_pg, s_tx, s_rx, s_cdr, rx_good, rx_ok;
    logic [2:0]        state_q, state_d;
    logic [3:0]        retry_q, retry_d, retry_inc;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              same_state;
    logic              reset_all_q, rx_dp_q, link_q, fail_q;

    // Wizard status outputs are asynchronous to clk_in.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {gtpowergood_in, reset_tx_done_in, reset_rx_done_in, rx_cdr_stable_in};
            sync_q <= meta_q;
        end
    end

    assign s_pg    = sync_q[3];
    assign s_tx    = sync_q[2];
    assign s_rx    = sync_q[1];
    assign s_cdr   = sync_q[0];
    assign rx_good = s_rx & s_cdr;

    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (restart_in) begin
            retry_d = '0;
            state_d = (state_q == PWR_WAIT && !s_pg) ? PWR_WAIT : RST_HOLD;
        end else if (!s_pg && state_q != PWR_WAIT && state_q != FAIL) begin
            state_d = PWR_WAIT;
        end else begin
            case (state_q)
                PWR_WAIT:   if (s_pg) state_d = RST_HOLD;
                RST_HOLD:   if (hold_cnt_q == HOLD_LAST) state_d = WAIT_TX;
                WAIT_TX: begin
                    if (s_tx)                        state_d = WAIT_RX;
                    else if (tmo_cnt_q == TMO_LAST) state_d = TIMEOUT;
                end
                WAIT_RX: begin
                    if (!s_tx)                       state_d = RST_HOLD;
                    else if (rx_ok)                  state_d = LINK_UP;
                    else if (tmo_cnt_q == TMO_LAST) state_d = TIMEOUT;
                end
                LINK_UP: begin
                    if (!s_tx)          state_d = RST_HOLD;
                    else if (!rx_good)  state_d = RX_RECOVER;
                end
                RX_RECOVER: if (hold_cnt_q == HOLD_LAST) state_d = WAIT_RX;
                TIMEOUT: begin
                    retry_d = retry_inc;
                    state_d = (retry_inc >= RETRY_LIM) ? FAIL : RST_HOLD;
                end
                FAIL:       state_d = FAIL;
            endcase
        end
    end

    // A restart re-enters RST_HOLD from RST_HOLD, so it must also clear the dwell counters.
    assign same_state = (state_d == state_q) && !restart_in;
    assign hold_cnt_d = ((state_q == RST_HOLD || state_q == RX_RECOVER) && same_state) ?
                        hold_cnt_q + 1'b1 : '0;
    assign tmo_cnt_d  = ((state_q == WAIT_TX || state_q == WAIT_RX) && same_state) ?
                        tmo_cnt_q + 1'b1 : '0;

`ifdef GTH_CTRL_STABLE_FILTER_EN
    localparam int unsigned STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);

    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;

    assign rx_ok      = rx_good && (stab_cnt_q == STAB_LAST);
    assign stab_cnt_d = (state_q == WAIT_RX && state_d == WAIT_RX && rx_good) ?
                        stab_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) stab_cnt_q <= '0;
        else           stab_cnt_q <= stab_cnt_d;
    end
`else
    logic unused_stable_cyc;
    assign unused_stable_cyc = ^STABLE_CYC;
    assign rx_ok             = rx_good;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= PWR_WAIT;
            retry_q    <= '0;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            reset_all_q <= 1'b1;
            rx_dp_q     <= 1'b0;
            link_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            reset_all_q <= (state_d == PWR_WAIT) || (state_d == RST_HOLD) || (state_d == FAIL);
            rx_dp_q     <= (state_d == RX_RECOVER);
            link_q      <= (state_d == LINK_UP);
            fail_q      <= (state_d == FAIL);
        end
    end

    assign reset_all_out         = reset_all_q;
    assign reset_rx_datapath_out = rx_dp_q;
    assign datagen_en_out        = link_q;
    assign link_up_out           = link_q;
    assign fail_out              = fail_q;
    assign retry_cnt_out         = retry_q;
    assign state_out             = state_q;

endmodule
